rr_arbiter_16: RTL and testbench
================================

Name: rr_arbiter_16

Overview:
16-requester round-robin arbiter with grant hold and timeout, sharing one downstream resource among 16 requesters.
Outputs a registered one-hot grant vector plus its 4-bit encoded index.
Sits in front of the one-hot-to-binary encoding path. The encoded index drives the resource's select and mux lines.

Parameters:
N, 16, number of requesters; fixed at 16 for this block.
IDX_W, 4, width of the encoded grant index; log2(N).
MAX_HOLD, 8, maximum consecutive cycles one grant may be held before forced release; legal range 1..256.

Ports:
clk  input  1  rising-edge clock; the single clock domain.
rst  input  1  synchronous, active-high reset, sampled on rising clk.
req  input  16  request vector; bit i high means requester i wants the resource.
done  input  1  current owner finished; release the grant at this edge.
gnt  output  16  registered one-hot grant; all zero when no owner.
gnt_idx  output  4  registered binary index of the set gnt bit; 0 when gnt is zero.
gnt_valid  output  1  registered; high iff gnt is nonzero.
hold_cnt  output  8  registered count of cycles the current grant has been held, starting at 0.

Behaviour:
- Reset (rst high at a clk edge, in any state, including mid-grant): gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, state=IDLE.
  - Internal last-owner pointer resets to 15, so requester 0 has first priority after reset.
  - rst has priority over every other input.
- States: IDLE (no owner) and GRANT (one owner held in gnt).
- Arbitration function:
  - Start at index last+1 and search upward, wrapping 15->0.
  - Pick the first i with req[i]=1.
  - The last owner is searched last, so it is re-granted only if it is the sole requester.
- IDLE:
  - If req is nonzero, the next edge loads gnt with the arbitrated one-hot value.
  - The same edge loads gnt_idx with the matching index, sets gnt_valid=1 and hold_cnt=0, and moves to GRANT.
  - Latency is exactly 1 cycle from req sampled to gnt visible.
  - If req is zero, stay in IDLE with outputs zero.
  - done is ignored in IDLE.
- GRANT, release condition (evaluated at each edge):
  - done=1, or
  - req[gnt_idx]=0 (requester withdrew), or
  - hold_cnt = MAX_HOLD-1, which forces a timeout.
- GRANT, no release: keep gnt/gnt_idx unchanged and increment hold_cnt (saturation is not reachable given the timeout).
- GRANT, release:
  - last <= gnt_idx.
  - Re-arbitrate on the same edge using the updated pointer and the current req.
  - If the result is nonzero, load the new grant with hold_cnt=0 and stay in GRANT. There is no bubble cycle between owners.
  - Otherwise clear gnt, gnt_idx and gnt_valid and go to IDLE.
- Timeout: a grant is visible for at most MAX_HOLD consecutive cycles. With MAX_HOLD=1, every grant lasts exactly 1 cycle.
- Simultaneous events:
  - done together with a timeout counts as one release.
  - done together with the owner dropping req counts as one release.
  - Requests arriving during GRANT wait; they never preempt the owner.
- Invariants, checked every cycle:
  - gnt is always zero or one-hot.
  - gnt_idx always equals the binary encoding of gnt.
  - gnt_valid equals OR of gnt.
  - A gnt bit is never set for a requester whose req was low at the granting edge.
- Fairness: with all 16 requesting continuously, each requester is granted once within any 16 consecutive grants.

Test Plan:
1. Reset: hold rst=1 with req=16'hFFFF for 2 cycles -> gnt=16'h0000, gnt_idx=0, gnt_valid=0, hold_cnt=0. First grant after reset release is gnt=16'h0001.
2. Single request: req=16'h0020 from IDLE -> 1 cycle later gnt=16'h0020, gnt_idx=5, gnt_valid=1. Pulse done -> next cycle gnt=16'h0020 again (sole requester re-granted), hold_cnt=0.
3. Rotation/wrap: req=16'hFFFF, done=1 every cycle -> gnt_idx sequence 0,1,2,...,15,0,1, one grant per cycle, no zero cycles.
4. Timeout: MAX_HOLD=8, req=16'h0208 held, done=0 -> gnt_idx=3 for exactly 8 cycles (hold_cnt 0..7), then gnt_idx=9 for 8 cycles, then 3 again.
5. Withdraw: owner idx 4 drops req[4] while req=16'h0000 otherwise -> next cycle gnt=0, gnt_valid=0, state IDLE. A later req=16'h0011 then grants idx 0 first (pointer is 4, so search starts at 5 and wraps to 0).
6. Reset mid-operation: while gnt_idx=12 and hold_cnt=3, assert rst for 1 cycle -> next edge all outputs zero. With req=16'hFFFF afterwards, next grant is idx 0.

Source files
------------

// File: rtl/rr_arbiter_16.sv
// 16-requester round-robin arbiter with grant hold, done-release and hold timeout.
// Grant, index, valid and hold count are all registered; owners hand over without a bubble.
module rr_arbiter_16 #(
    parameter int N        = 16,
    parameter int IDX_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             done,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic [7:0]       hold_cnt
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] last, last_nxt;
    logic [N-1:0]     gnt_nxt;
    logic [IDX_W-1:0] idx_nxt;
    logic             valid_nxt;
    logic [7:0]       hold_nxt;

    logic             rel;
    logic [IDX_W-1:0] base;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;

    assign rel = (state == GRANT) &&
                 (done || !req[gnt_idx] || (hold_cnt == 8'(MAX_HOLD - 1)));

    // A releasing owner becomes the pointer on the same edge it re-arbitrates.
    assign base = rel ? gnt_idx : last;

    // Offset N wraps back to base, so the previous owner is searched last.
    always_comb begin
        pick_idx   = '0;
        pick_found = 1'b0;
        cand       = '0;
        for (int k = 1; k <= N; k++) begin
            cand = base + IDX_W'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        gnt_nxt   = gnt;
        idx_nxt   = gnt_idx;
        valid_nxt = gnt_valid;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    gnt_nxt   = N'(1) << pick_idx;
                    idx_nxt   = pick_idx;
                    valid_nxt = 1'b1;
                    hold_nxt  = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    last_nxt = gnt_idx;
                    if (pick_found) begin
                        gnt_nxt   = N'(1) << pick_idx;
                        idx_nxt   = pick_idx;
                        valid_nxt = 1'b1;
                        hold_nxt  = '0;
                    end else begin
                        gnt_nxt   = '0;
                        idx_nxt   = '0;
                        valid_nxt = 1'b0;
                        hold_nxt  = '0;
                        state_nxt = IDLE;
                    end
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= IDX_W'(N - 1);
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            last      <= last_nxt;
            gnt       <= gnt_nxt;
            gnt_idx   <= idx_nxt;
            gnt_valid <= valid_nxt;
            hold_cnt  <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_16.sv
// Directed bench for rr_arbiter_16: reset, single request, rotation, timeout,
// withdraw and mid-grant reset, plus per-cycle structural invariants.
module tb_rr_arbiter_16;

    logic        clk;
    logic        rst;
    logic [15:0] req;
    logic        done;
    logic [15:0] gnt;
    logic [3:0]  gnt_idx;
    logic        gnt_valid;
    logic [7:0]  hold_cnt;

    int checks = 0;
    int errors = 0;
    logic [15:0] req_at_edge;
    logic [15:0] gnt_before;

    rr_arbiter_16 #(.N(16), .IDX_W(4), .MAX_HOLD(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .hold_cnt  (hold_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, then check the structural invariants.
    task automatic step();
        logic [3:0] enc;
        req_at_edge = req;
        gnt_before  = gnt;
        @(posedge clk);
        #1;
        enc = 4'd0;
        for (int i = 0; i < 16; i++)
            if (gnt[i]) enc = 4'(i);
        check("inv_onehot0", 32'($onehot0(gnt)), 32'd1);
        check("inv_idx_enc", 32'(gnt_idx), 32'(enc));
        check("inv_valid", 32'(gnt_valid), 32'(|gnt));
        if (gnt_valid && hold_cnt == 8'd0 && !rst)
            check("inv_req_at_grant", 32'(gnt & ~req_at_edge), 32'd0);
    endtask

    task automatic check_out(input string tag, input logic [15:0] eg, input logic [3:0] ei,
                             input logic ev, input logic [7:0] eh);
        check({tag, "_gnt"}, 32'(gnt), 32'(eg));
        check({tag, "_idx"}, 32'(gnt_idx), 32'(ei));
        check({tag, "_valid"}, 32'(gnt_valid), 32'(ev));
        check({tag, "_hold"}, 32'(hold_cnt), 32'(eh));
    endtask

    initial begin
        rst  = 1'b1;
        req  = 16'hFFFF;
        done = 1'b0;
        #1;

        // 1. Reset with all requesting.
        step();
        step();
        check_out("reset", 16'h0000, 4'd0, 1'b0, 8'd0);
        rst = 1'b0;
        step();
        check_out("first_after_reset", 16'h0001, 4'd0, 1'b1, 8'd0);
        req = 16'h0000;
        step();
        check_out("drop_to_idle", 16'h0000, 4'd0, 1'b0, 8'd0);

        // 2. Single request, done re-grants the sole requester.
        req = 16'h0020;
        step();
        check_out("single", 16'h0020, 4'd5, 1'b1, 8'd0);
        step();
        check_out("single_hold", 16'h0020, 4'd5, 1'b1, 8'd1);
        done = 1'b1;
        step();
        check_out("single_regrant", 16'h0020, 4'd5, 1'b1, 8'd0);
        done = 1'b0;

        // 3. Rotation and wrap with done every cycle (done ignored on the IDLE edge).
        rst = 1'b1;
        step();
        rst  = 1'b0;
        req  = 16'hFFFF;
        done = 1'b1;
        for (int i = 0; i < 18; i++) begin
            step();
            check_out($sformatf("rot%0d", i), 16'(1 << (i % 16)), 4'(i % 16), 1'b1, 8'd0);
        end
        req = 16'h0000;
        step();
        check_out("rot_idle", 16'h0000, 4'd0, 1'b0, 8'd0);
        done = 1'b0;

        // 4. Timeout alternation: pointer=1, so 3 first, then 9, then 3.
        req = 16'h0208;
        for (int s = 0; s < 17; s++) begin
            step();
            check_out($sformatf("tmo%0d", s), ((s / 8) % 2) ? 16'h0200 : 16'h0008,
                      ((s / 8) % 2) ? 4'd9 : 4'd3, 1'b1, 8'(s % 8));
        end

        // 5. Withdraw: owner 4 drops, then 0x0011 wraps to idx 0.
        req = 16'h0000;
        step();
        check_out("wd_idle0", 16'h0000, 4'd0, 1'b0, 8'd0);
        req = 16'h0010;
        step();
        check_out("wd_own4", 16'h0010, 4'd4, 1'b1, 8'd0);
        req = 16'h0000;
        step();
        check_out("wd_release", 16'h0000, 4'd0, 1'b0, 8'd0);
        req = 16'h0011;
        step();
        check_out("wd_wrap", 16'h0001, 4'd0, 1'b1, 8'd0);

        // 6. Reset mid-grant at idx 12, hold 3.
        req = 16'h1000;
        step();
        check_out("mid_own12", 16'h1000, 4'd12, 1'b1, 8'd0);
        step();
        step();
        step();
        check_out("mid_hold3", 16'h1000, 4'd12, 1'b1, 8'd3);
        rst = 1'b1;
        req = 16'hFFFF;
        step();
        check_out("mid_reset", 16'h0000, 4'd0, 1'b0, 8'd0);
        rst = 1'b0;
        step();
        check_out("mid_after", 16'h0001, 4'd0, 1'b1, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
